// File: rtl/axis_pkt_fifo.sv
// ----------------------------------------------------------------------------
// axis_pkt_fifo
//   Single-clock AXI4-Stream FIFO with first-word fall-through output,
//   optional store-and-forward packet mode, fill level, complete-packet count
//   and an almost-full flag.
//
// Parameters
//   WIDTH         TDATA width in bits
//   DEPTH         number of entries (power of 2, >= 2)
//   PKT_MODE      0 = cut-through, 1 = store-and-forward
//   AFULL_THRESH  almost_full asserts when level >= AFULL_THRESH
//
// Ports
//   clk, rstn                       clock (posedge), async active-low reset
//   S_AXIS_TDATA/TLAST/TVALID       write side inputs
//   S_AXIS_TREADY                   registered "not full" towards producer
//   M_AXIS_TDATA/TLAST/TVALID       head-of-FIFO word towards consumer
//   M_AXIS_TREADY                   consumer accepts head word
//   level                           words stored (0..DEPTH)
//   pkt_count                       stored words carrying TLAST
//   almost_full                     level >= AFULL_THRESH
// ----------------------------------------------------------------------------
module axis_pkt_fifo #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 16,
    parameter int PKT_MODE     = 0,
    parameter int AFULL_THRESH = 12
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [WIDTH-1:0]         S_AXIS_TDATA,
    input  logic                     S_AXIS_TLAST,
    input  logic                     S_AXIS_TVALID,
    output logic                     S_AXIS_TREADY,
    output logic [WIDTH-1:0]         M_AXIS_TDATA,
    output logic                     M_AXIS_TLAST,
    output logic                     M_AXIS_TVALID,
    input  logic                     M_AXIS_TREADY,
    output logic [$clog2(DEPTH):0]   level,
    output logic [$clog2(DEPTH):0]   pkt_count,
    output logic                     almost_full
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);
    localparam logic [AW:0] AFULL_L = (AW+1)'(AFULL_THRESH);

    logic [WIDTH:0] mem_q [DEPTH];

    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]    pkt_cnt_q, pkt_cnt_d;
    logic           drain_q, drain_d;
    logic           s_tready_q, s_tready_d;

    logic           wr_fire, rd_fire;
    logic           full;
    logic           m_tvalid;
    logic [WIDTH:0] head;
    logic [AW:0]    level_c;

    // Head entry is read combinationally so a word written at one edge is
    // presented on M_AXIS immediately after it.
    always_comb begin
        head     = mem_q[rd_ptr_q[AW-1:0]];
        level_c  = wr_ptr_q - rd_ptr_q;
        full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
        if (PKT_MODE == 0) begin
            m_tvalid = (level_c != '0);
        end else begin
            m_tvalid = (level_c != '0) && ((pkt_cnt_q != '0) || drain_q);
        end
        wr_fire  = S_AXIS_TVALID && s_tready_q;
        rd_fire  = m_tvalid && M_AXIS_TREADY;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        drain_d   = drain_q;

        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + ONE;
        end

        unique case ({wr_fire && S_AXIS_TLAST, rd_fire && head[WIDTH]})
            2'b10:   pkt_cnt_d = pkt_cnt_q + ONE;
            2'b01:   pkt_cnt_d = pkt_cnt_q - ONE;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase

        // A full FIFO holding no complete packet can never finish one on its
        // own; release the partial packet cut-through until its TLAST leaves.
        if (rd_fire && head[WIDTH]) begin
            drain_d = 1'b0;
        end
        if (full && (pkt_cnt_q == '0)) begin
            drain_d = 1'b1;
        end

        // Ready is a register: it looks at the post-edge pointers so it never
        // depends combinationally on M_AXIS_TREADY.
        s_tready_d = !((wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) &&
                       (wr_ptr_d[AW] != rd_ptr_d[AW]));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pkt_cnt_q  <= '0;
            drain_q    <= 1'b0;
            s_tready_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drain_q    <= drain_d;
            s_tready_q <= s_tready_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {S_AXIS_TLAST, S_AXIS_TDATA};
        end
    end

    always_comb begin
        S_AXIS_TREADY = s_tready_q;
        M_AXIS_TVALID = m_tvalid;
        M_AXIS_TDATA  = head[WIDTH-1:0];
        M_AXIS_TLAST  = head[WIDTH];
        level         = level_c;
        pkt_count     = pkt_cnt_q;
        almost_full   = (level_c >= AFULL_L);
    end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// ----------------------------------------------------------------------------
// tb_axis_pkt_fifo
//   Instance 0: cut-through (PKT_MODE=0); instance 1: store-and-forward.
//   A queue-style reference model tracks the stored words per instance and a
//   single negedge process compares every DUT output against it each cycle.
// ----------------------------------------------------------------------------
module tb_axis_pkt_fifo;

    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;

    logic [7:0] s_tdata  [2];
    logic       s_tlast  [2];
    logic       s_tvalid [2];
    logic       s_tready [2];
    logic [7:0] m_tdata  [2];
    logic       m_tlast  [2];
    logic       m_tvalid [2];
    logic       m_tready [2];
    logic [4:0] level_o  [2];
    logic [4:0] pkt_o    [2];
    logic       afull_o  [2];

    always #5 clk = ~clk;

    axis_pkt_fifo #(.WIDTH(8), .DEPTH(DEPTH), .PKT_MODE(0), .AFULL_THRESH(AFULL)) u_ct (
        .clk(clk), .rstn(rstn),
        .S_AXIS_TDATA(s_tdata[0]), .S_AXIS_TLAST(s_tlast[0]),
        .S_AXIS_TVALID(s_tvalid[0]), .S_AXIS_TREADY(s_tready[0]),
        .M_AXIS_TDATA(m_tdata[0]), .M_AXIS_TLAST(m_tlast[0]),
        .M_AXIS_TVALID(m_tvalid[0]), .M_AXIS_TREADY(m_tready[0]),
        .level(level_o[0]), .pkt_count(pkt_o[0]), .almost_full(afull_o[0])
    );

    axis_pkt_fifo #(.WIDTH(8), .DEPTH(DEPTH), .PKT_MODE(1), .AFULL_THRESH(AFULL)) u_sf (
        .clk(clk), .rstn(rstn),
        .S_AXIS_TDATA(s_tdata[1]), .S_AXIS_TLAST(s_tlast[1]),
        .S_AXIS_TVALID(s_tvalid[1]), .S_AXIS_TREADY(s_tready[1]),
        .M_AXIS_TDATA(m_tdata[1]), .M_AXIS_TLAST(m_tlast[1]),
        .M_AXIS_TVALID(m_tvalid[1]), .M_AXIS_TREADY(m_tready[1]),
        .level(level_o[1]), .pkt_count(pkt_o[1]), .almost_full(afull_o[1])
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Words ever written / read are numbered; the stored words are the ones
    // with index in [rcnt, wcnt).
    logic [8:0] mq [2][256];
    int         wcnt [2];
    int         rcnt [2];
    bit         drain_m [2];
    bit         tready_m [2];

    function automatic int m_level(input int i);
        return wcnt[i] - rcnt[i];
    endfunction

    function automatic int m_pkts(input int i);
        int n = 0;
        for (int k = rcnt[i]; k < wcnt[i]; k++) begin
            if (mq[i][k % 256][8]) n++;
        end
        return n;
    endfunction

    function automatic bit m_valid(input int i);
        if (m_level(i) == 0) return 1'b0;
        if (i == 0) return 1'b1;
        return (m_pkts(i) != 0) || drain_m[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            wcnt[i]     = 0;
            rcnt[i]     = 0;
            drain_m[i]  = 1'b0;
            tready_m[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit wr, rd, hl, dn;
            wr = s_tvalid[i] && tready_m[i];
            rd = m_valid(i) && m_tready[i];
            hl = mq[i][rcnt[i] % 256][8];
            dn = drain_m[i];
            if (rd && hl) dn = 1'b0;
            if (m_level(i) == DEPTH && m_pkts(i) == 0) dn = 1'b1;
            drain_m[i] = dn;
            if (rd) rcnt[i]++;
            if (wr) begin
                mq[i][wcnt[i] % 256] = {s_tlast[i], s_tdata[i]};
                wcnt[i]++;
            end
            tready_m[i] = (m_level(i) != DEPTH);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) model_reset();
            else       model_edge();
        end
    end

    // ---------------- per-cycle compare + read log ----------------
    logic [8:0] rx [2][256];
    int         rxn [2];

    initial begin
        rxn[0] = 0;
        rxn[1] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                logic [8:0] h;
                bit ev;
                h  = mq[i][rcnt[i] % 256];
                ev = m_valid(i);
                chk($sformatf("i%0d_s_tready", i), int'(s_tready[i]), int'(tready_m[i]));
                chk($sformatf("i%0d_m_tvalid", i), int'(m_tvalid[i]), int'(ev));
                chk($sformatf("i%0d_level", i), int'(level_o[i]), m_level(i));
                chk($sformatf("i%0d_pkt_count", i), int'(pkt_o[i]), m_pkts(i));
                chk($sformatf("i%0d_almost_full", i), int'(afull_o[i]), int'(m_level(i) >= AFULL));
                if (ev) begin
                    chk($sformatf("i%0d_m_tdata", i), int'(m_tdata[i]), int'(h[7:0]));
                    chk($sformatf("i%0d_m_tlast", i), int'(m_tlast[i]), int'(h[8]));
                end
                if (m_tvalid[i] && m_tready[i]) begin
                    rx[i][rxn[i] % 256] = {m_tlast[i], m_tdata[i]};
                    rxn[i]++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input int d, input bit last);
        bit acc = 1'b0;
        s_tvalid[i] = 1'b1;
        s_tdata[i]  = 8'(d);
        s_tlast[i]  = last;
        for (int n = 0; n < 64 && !acc; n++) begin
            @(negedge clk);
            acc = s_tready[i];
            @(posedge clk);
            #1;
        end
        if (!acc) chk($sformatf("i%0d_push_timeout", i), 0, 1);
    endtask

    task automatic idle(input int i);
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
    endtask

    task automatic drain_out(input int i);
        int n = 0;
        m_tready[i] = 1'b1;
        while (level_o[i] != 0 && n < 64) begin
            step();
            n++;
        end
        if (n == 64) chk($sformatf("i%0d_drain_timeout", i), 0, 1);
        m_tready[i] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        int b;
        for (int i = 0; i < 2; i++) begin
            s_tdata[i]  = '0;
            s_tlast[i]  = 1'b0;
            s_tvalid[i] = 1'b0;
            m_tready[i] = 1'b0;
        end

        // Reset state, then ready rises on the first edge after release.
        #12;
        chk("rst_s_tready", int'(s_tready[0]), 0);
        chk("rst_m_tvalid", int'(m_tvalid[0]), 0);
        chk("rst_level", int'(level_o[0]), 0);
        #11 rstn = 1'b1;
        step();
        chk("rel_s_tready_ct", int'(s_tready[0]), 1);
        chk("rel_s_tready_sf", int'(s_tready[1]), 1);

        // 1: five words in, then read out one per cycle.
        for (int k = 1; k <= 5; k++) push(0, k, 1'b0);
        idle(0);
        chk("t1_level5", int'(level_o[0]), 5);
        m_tready[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("t1_tvalid", int'(m_tvalid[0]), 1);
            chk("t1_tdata", int'(m_tdata[0]), k + 1);
            chk("t1_level", int'(level_o[0]), 5 - k);
            step();
        end
        chk("t1_level0", int'(level_o[0]), 0);
        chk("t1_empty", int'(m_tvalid[0]), 0);
        m_tready[0] = 1'b0;

        // 2: fill to full, almost_full from 12, read while a write is stalled.
        for (int k = 0; k < DEPTH; k++) begin
            push(0, 8'h10 + k, 1'b0);
            chk("t2_afull", int'(afull_o[0]), int'(k + 1 >= 12));
        end
        idle(0);
        chk("t2_full_tready", int'(s_tready[0]), 0);
        chk("t2_level16", int'(level_o[0]), 16);
        s_tvalid[0] = 1'b1;
        s_tdata[0]  = 8'hEE;
        m_tready[0] = 1'b1;
        step();
        idle(0);
        m_tready[0] = 1'b0;
        chk("t2_level15", int'(level_o[0]), 15);
        chk("t2_tready_back", int'(s_tready[0]), 1);
        drain_out(0);
        chk("t2_level0", int'(level_o[0]), 0);

        // 5: streaming write+read for 40 words; consecutive TLAST words 7/8.
        b = rxn[0];
        m_tready[0] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            push(0, k, (k % 8 == 7) || (k % 8 == 0 && k > 0));
            chk("t5_level1", int'(level_o[0]), 1);
            if (k == 8) chk("t5_pkt_same_edge", int'(pkt_o[0]), 1);
            if (k == 9) chk("t5_pkt_after", int'(pkt_o[0]), 0);
        end
        idle(0);
        step();
        m_tready[0] = 1'b0;
        chk("t5_level0", int'(level_o[0]), 0);
        chk("t5_count", rxn[0] - b, 40);
        for (int j = 0; j < 40; j++) begin
            logic [8:0] w;
            w = rx[0][(b + j) % 256];
            chk("t5_data", int'(w[7:0]), j);
        end

        // 6: async reset mid-operation, then fresh data only.
        for (int k = 0; k < 7; k++) push(0, 8'h60 + k, k == 3);
        idle(0);
        chk("t6_level7", int'(level_o[0]), 7);
        chk("t6_pkt1", int'(pkt_o[0]), 1);
        #2 rstn = 1'b0;
        #1;
        chk("t6_rst_tvalid", int'(m_tvalid[0]), 0);
        chk("t6_rst_tready", int'(s_tready[0]), 0);
        chk("t6_rst_level", int'(level_o[0]), 0);
        chk("t6_rst_pkt", int'(pkt_o[0]), 0);
        #10 rstn = 1'b1;
        step();
        step();
        chk("t6_tready_again", int'(s_tready[0]), 1);
        b = rxn[0];
        push(0, 8'hA0, 1'b1);
        push(0, 8'hA1, 1'b1);
        idle(0);
        drain_out(0);
        chk("t6_count", rxn[0] - b, 2);
        begin
            logic [8:0] w0, w1;
            w0 = rx[0][b % 256];
            w1 = rx[0][(b + 1) % 256];
            chk("t6_data0", int'(w0[7:0]), 8'hA0);
            chk("t6_data1", int'(w1[7:0]), 8'hA1);
        end

        // 3: store-and-forward holds a packet until its TLAST is stored.
        for (int k = 0; k < 4; k++) begin
            push(1, 8'h31 + k, k == 3);
            chk("t3_tvalid", int'(m_tvalid[1]), int'(k == 3));
        end
        idle(1);
        chk("t3_pkt1", int'(pkt_o[1]), 1);
        m_tready[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t3_tdata", int'(m_tdata[1]), 8'h31 + k);
            step();
        end
        m_tready[1] = 1'b0;
        chk("t3_pkt0", int'(pkt_o[1]), 0);
        chk("t3_tvalid_off", int'(m_tvalid[1]), 0);

        // 4: oversize packet fills the FIFO and is released by drain.
        b = rxn[1];
        for (int k = 0; k < DEPTH; k++) push(1, 8'h40 + k, 1'b0);
        idle(1);
        chk("t4_full_tready", int'(s_tready[1]), 0);
        chk("t4_level16", int'(level_o[1]), 16);
        step();
        chk("t4_drain_tvalid", int'(m_tvalid[1]), 1);
        m_tready[1] = 1'b1;
        for (int k = DEPTH; k < 20; k++) push(1, 8'h40 + k, k == 19);
        idle(1);
        drain_out(1);
        chk("t4_count", rxn[1] - b, 20);
        for (int j = 0; j < 20; j++) begin
            logic [8:0] w;
            w = rx[1][(b + j) % 256];
            chk("t4_data", int'(w[7:0]), 8'h40 + j);
            chk("t4_last", int'(w[8]), int'(j == 19));
        end
        chk("t4_tvalid_end", int'(m_tvalid[1]), 0);

        step();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
